// File: rtl/warp_issue_scheduler.sv
// Warp issue scheduler: round-robin pick of a hazard-free warp, IB pop, registered
// valid/ready issue stage and CTA-wide barrier. Define WARP_SCHED_GREEDY_EN for greedy-then-round-robin.
module warp_issue_scheduler #(
  parameter int NUM_WARPS = 32,
  parameter int WARP_ID_W = 5,
  parameter int INST_W    = 63,
  parameter int BAR_BIT   = 62
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_WARPS-1:0] warp_active_mask,
  input  logic [NUM_WARPS-1:0] warp_ready_mask,
  output logic [WARP_ID_W-1:0] sel_warp_id,
  input  logic [INST_W-1:0]    inst_in,
  output logic                 pop_valid,
  output logic [WARP_ID_W-1:0] pop_warp_id,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic [WARP_ID_W-1:0] m_warp_id,
  output logic [INST_W-1:0]    m_instruction,
  output logic [NUM_WARPS-1:0] bar_wait_mask,
  output logic                 bar_release,
  output logic                 err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t               state, state_next;
  logic [WARP_ID_W-1:0] last_issued;
  logic [WARP_ID_W-1:0] rr_ptr, rr_ptr_next;
  logic [WARP_ID_W-1:0] winner;
  logic                 any_elig;
  logic [NUM_WARPS-1:0] elig;
  logic [NUM_WARPS-1:0] arrive;
  logic [NUM_WARPS-1:0] wait_next;
  logic                 can_issue;
  logic                 issue;
  logic                 is_bar;
  logic                 covered;
  logic                 tvalid_next;
  logic                 err_next;

  assign elig      = warp_ready_mask & warp_active_mask & ~bar_wait_mask;
  assign can_issue = !m_tvalid || m_tready;
  assign is_bar    = inst_in[BAR_BIT];
  assign issue     = (state == RUN) && any_elig && can_issue;

  assign sel_warp_id = winner;
  assign pop_valid   = issue;
  assign pop_warp_id = winner;
  assign bar_release = (state == RELEASE);

  // rr_ptr is the first slot searched; it is one past last_issued except right after reset.
  always_comb begin : select
    logic [WARP_ID_W:0] pos;
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    winner   = last_issued;
    any_elig = 1'b0;
    pos      = '0;
`ifdef WARP_SCHED_GREEDY_EN
    if (elig[last_issued]) begin
      winner   = last_issued;
      any_elig = 1'b1;
    end
`endif
    for (int i = 0; i < NUM_WARPS; i++) begin
      pos = {1'b0, rr_ptr} + (WARP_ID_W+1)'(i);
      if (pos >= (WARP_ID_W+1)'(NUM_WARPS)) begin
        pos = pos - (WARP_ID_W+1)'(NUM_WARPS);
      end
      if (!any_elig && elig[pos[WARP_ID_W-1:0]]) begin
        winner   = pos[WARP_ID_W-1:0];
        any_elig = 1'b1;
      end
    end
  end

  always_comb begin
    rr_ptr_next = rr_ptr;
    if (issue) begin
      rr_ptr_next = (winner == WARP_ID_W'(NUM_WARPS-1)) ? '0 : winner + 1'b1;
    end
  end

  always_comb begin
    arrive = '0;
    if (issue && is_bar) begin
      arrive[winner] = 1'b1;
    end
  end

  // Exited warps drop out of both sides of the check, so a warp exit can open the barrier.
  assign covered = ((warp_active_mask & ~(bar_wait_mask | arrive)) == '0);

  always_comb begin
    state_next = state;
    wait_next  = bar_wait_mask;
    case (state)
      IDLE: begin
        wait_next = '0;
        if (|warp_active_mask) begin
          state_next = RUN;
        end
      end
      RUN: begin
        wait_next = (bar_wait_mask | arrive) & warp_active_mask;
        if (!(|warp_active_mask)) begin
          if (!m_tvalid) begin
            state_next = IDLE;
          end
        end else if (covered) begin
          state_next = RELEASE;
          wait_next  = '0;
        end
      end
      RELEASE: begin
        wait_next  = '0;
        state_next = RUN;
      end
      default: begin
        wait_next  = '0;
        state_next = IDLE;
      end
    endcase
  end

  // Barrier entries are consumed here; they only free the slot if dispatch took it.
  always_comb begin
    tvalid_next = m_tvalid;
    if (issue && !is_bar) begin
      tvalid_next = 1'b1;
    end else if (m_tready) begin
      tvalid_next = 1'b0;
    end
  end

  assign err_next = err
                  | (|(warp_ready_mask & ~warp_active_mask))
                  | (m_tvalid && !m_tready && !tvalid_next);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      last_issued   <= '0;
      rr_ptr        <= '0;
      bar_wait_mask <= '0;
      m_tvalid      <= 1'b0;
      m_warp_id     <= '0;
      m_instruction <= '0;
      err           <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state         <= state_next;
      rr_ptr        <= rr_ptr_next;
      bar_wait_mask <= wait_next;
      m_tvalid      <= tvalid_next;
      err           <= err_next;
      if (issue) begin
        last_issued <= winner;
      end
      if (issue && !is_bar) begin
        m_warp_id     <= winner;
        m_instruction <= inst_in;
      end
    end
  end

endmodule

// File: tb/tb_warp_issue_scheduler.sv
// Directed self-checking bench for warp_issue_scheduler: round-robin, backpressure,
// barrier arrival/exit release, sticky error and asynchronous reset.
module tb_warp_issue_scheduler;
  localparam int NW      = 32;
  localparam int IW      = 5;
  localparam int INST_W  = 63;
  localparam int BAR_BIT = 62;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NW-1:0]     warp_active_mask;
  logic [NW-1:0]     warp_ready_mask;
  logic [IW-1:0]     sel_warp_id;
  logic [INST_W-1:0] inst_in;
  logic              pop_valid;
  logic [IW-1:0]     pop_warp_id;
  logic              m_tvalid;
  logic              m_tready;
  logic [IW-1:0]     m_warp_id;
  logic [INST_W-1:0] m_instruction;
  logic [NW-1:0]     bar_wait_mask;
  logic              bar_release;
  logic              err;

  logic [NW-1:0]     bar_head;

  int tests_run    = 0;
  int tests_failed = 0;

  warp_issue_scheduler #(
    .NUM_WARPS(NW), .WARP_ID_W(IW), .INST_W(INST_W), .BAR_BIT(BAR_BIT)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .warp_active_mask (warp_active_mask),
    .warp_ready_mask  (warp_ready_mask),
    .sel_warp_id      (sel_warp_id),
    .inst_in          (inst_in),
    .pop_valid        (pop_valid),
    .pop_warp_id      (pop_warp_id),
    .m_tvalid         (m_tvalid),
    .m_tready         (m_tready),
    .m_warp_id        (m_warp_id),
    .m_instruction    (m_instruction),
    .bar_wait_mask    (bar_wait_mask),
    .bar_release      (bar_release),
    .err              (err)
  );

  always #5 clk = ~clk;

  // Instruction buffer model: head entry carries its warp id and a per-warp barrier flag.
  always_comb begin
    inst_in = {bar_head[sel_warp_id], 57'h0, sel_warp_id};
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  initial begin
    logic [IW-1:0]     exp_pop;
    logic [IW-1:0]     prev;
    logic [INST_W-1:0] exp_inst;
    warp_active_mask = '0;
    warp_ready_mask  = '0;
    m_tready         = 1'b0;
    bar_head         = '0;
    prev             = '0;

    repeat (2) @(negedge clk);
    #1;
    check("rst_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_warp_id", 64'(m_warp_id), 64'd0);
    check("rst_inst", 64'(m_instruction), 64'd0);
    check("rst_pop", 64'(pop_valid), 64'd0);
    check("rst_wait", 64'(bar_wait_mask), 64'd0);
    check("rst_release", 64'(bar_release), 64'd0);
    check("rst_err", 64'(err), 64'd0);

    @(negedge clk);
    rst_n = 1'b1;

    // Round-robin over warps 0..3
    @(negedge clk);
    warp_active_mask = 32'hF;
    warp_ready_mask  = 32'hF;
    m_tready         = 1'b1;
    #1 check("idle_no_pop", 64'(pop_valid), 64'd0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      #1;
`ifdef WARP_SCHED_GREEDY_EN
      exp_pop = '0;
`else
      exp_pop = IW'(k % 4);
`endif
      check("rr_pop_valid", 64'(pop_valid), 64'd1);
      check("rr_pop_id", 64'(pop_warp_id), 64'(exp_pop));
      if (k == 0) begin
        check("rr_first_tvalid", 64'(m_tvalid), 64'd0);
      end else begin
        exp_inst = {1'b0, 57'h0, prev};
        check("rr_tvalid", 64'(m_tvalid), 64'd1);
        check("rr_m_warp", 64'(m_warp_id), 64'(prev));
        check("rr_m_inst", 64'(m_instruction), 64'(exp_inst));
      end
      prev = exp_pop;
    end

    // Backpressure: output holds, no pops
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      m_tready = 1'b0;
      #1;
      check("bp_no_pop", 64'(pop_valid), 64'd0);
      check("bp_tvalid", 64'(m_tvalid), 64'd1);
      check("bp_hold_warp", 64'(m_warp_id), 64'(prev));
    end
    @(negedge clk);
    m_tready = 1'b1;
    #1;
    check("bp_resume_pop", 64'(pop_valid), 64'd1);
    check("bp_resume_id", 64'(pop_warp_id), 64'd0);
    @(negedge clk);
    warp_ready_mask = '0;
    #1;
    check("bp_resume_m_warp", 64'(m_warp_id), 64'd0);
    check("bp_resume_tvalid", 64'(m_tvalid), 64'd1);
    check("quiet_no_pop", 64'(pop_valid), 64'd0);
    @(negedge clk);
    #1 check("drain_tvalid", 64'(m_tvalid), 64'd0);

    // Barrier: warps 0,1,2 arrive in turn
    @(negedge clk);
    warp_active_mask = 32'h7;
    warp_ready_mask  = 32'h1;
    bar_head         = 32'h7;
    #1;
    check("bar0_pop", 64'(pop_valid), 64'd1);
    check("bar0_id", 64'(pop_warp_id), 64'd0);
    @(negedge clk);
    warp_ready_mask = 32'h2;
    #1;
    check("bar0_wait", 64'(bar_wait_mask), 64'h1);
    check("bar0_no_fwd", 64'(m_tvalid), 64'd0);
    check("bar1_id", 64'(pop_warp_id), 64'd1);
    @(negedge clk);
    warp_ready_mask = 32'h4;
    #1;
    check("bar1_wait", 64'(bar_wait_mask), 64'h3);
    check("bar1_no_fwd", 64'(m_tvalid), 64'd0);
    check("bar2_id", 64'(pop_warp_id), 64'd2);
    check("bar2_no_release", 64'(bar_release), 64'd0);
    @(negedge clk);
    warp_ready_mask = '0;
    #1;
    check("bar_release", 64'(bar_release), 64'd1);
    check("bar_cleared", 64'(bar_wait_mask), 64'd0);
    check("bar_rel_no_fwd", 64'(m_tvalid), 64'd0);
    check("bar_rel_no_pop", 64'(pop_valid), 64'd0);
    @(negedge clk);
    #1 check("bar_pulse_end", 64'(bar_release), 64'd0);

    // Barrier opened by warp exit
    @(negedge clk);
    warp_ready_mask = 32'h1;
    bar_head        = 32'h3;
    #1 check("exit_pop0", 64'(pop_warp_id), 64'd0);
    @(negedge clk);
    warp_ready_mask = 32'h2;
    #1;
    check("exit_wait0", 64'(bar_wait_mask), 64'h1);
    check("exit_pop1", 64'(pop_warp_id), 64'd1);
    @(negedge clk);
    warp_ready_mask  = '0;
    warp_active_mask = 32'h3;
    #1;
    check("exit_wait01", 64'(bar_wait_mask), 64'h3);
    check("exit_not_yet", 64'(bar_release), 64'd0);
    @(negedge clk);
    #1;
    check("exit_release", 64'(bar_release), 64'd1);
    check("exit_cleared", 64'(bar_wait_mask), 64'd0);
    @(negedge clk);
    #1 check("exit_pulse_end", 64'(bar_release), 64'd0);

    // Sticky error on ready outside active
    @(negedge clk);
    bar_head         = '0;
    warp_active_mask = 32'hF;
    warp_ready_mask  = 32'h10;
    #1 check("err_before", 64'(err), 64'd0);
    @(negedge clk);
    warp_ready_mask = '0;
    #1 check("err_set", 64'(err), 64'd1);
    @(negedge clk);
    #1 check("err_sticky", 64'(err), 64'd1);

    // Asynchronous reset with an instruction in flight
    @(negedge clk);
    warp_ready_mask = 32'hF;
    #1 check("pre_rst_pop", 64'(pop_valid), 64'd1);
    @(negedge clk);
    #1 check("pre_rst_tvalid", 64'(m_tvalid), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_tvalid", 64'(m_tvalid), 64'd0);
    check("arst_pop", 64'(pop_valid), 64'd0);
    check("arst_err", 64'(err), 64'd0);
    check("arst_warp", 64'(m_warp_id), 64'd0);
    check("arst_inst", 64'(m_instruction), 64'd0);
    check("arst_wait", 64'(bar_wait_mask), 64'd0);

`ifdef WARP_SCHED_GREEDY_EN
    // Greedy: warp 0 keeps issuing while eligible
    @(negedge clk);
    rst_n            = 1'b1;
    warp_active_mask = 32'h3;
    warp_ready_mask  = 32'h3;
    m_tready         = 1'b1;
    for (int g = 0; g < 3; g++) begin
      @(negedge clk);
      #1 check("greedy_hold", 64'(pop_warp_id), 64'd0);
    end
    @(negedge clk);
    warp_ready_mask = 32'h2;
    #1 check("greedy_switch", 64'(pop_warp_id), 64'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
